// File: rtl/call_stack_param.sv
// Parametrised circular return-address stack with sticky overflow/underflow flags.
// Optional macro STACK_FAULT_RST_EN enables a registered, sticky fault reset request.
module call_stack_param #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] tos,
  input  logic              tos_wr_en,
  input  logic [ADDR_W-1:0] tos_wr_data,
  input  logic              ptr_wr_en,
  input  logic [CNT_W-1:0]  ptr_wr_data,
  output logic [CNT_W-1:0]  stkptr,
  output logic              full,
  output logic              empty,
  input  logic              clr_flags,
  output logic              stkovf,
  output logic              stkunf,
  output logic              fault_rst_req
);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_unf;

  logic [PTR_W-1:0]  w_top;
  logic [CNT_W-1:0]  w_clamp;
  logic              w_empty;
  logic              w_full;
  logic              w_mem_we;
  logic [PTR_W-1:0]  w_mem_addr;
  logic [ADDR_W-1:0] w_mem_data;
  logic [PTR_W-1:0]  w_wp_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_ovf_set;
  logic              w_unf_set;

  assign w_top   = r_wp - PTR_W'(1);
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(DEPTH));
  assign w_clamp = (ptr_wr_data > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : ptr_wr_data;

  assign tos    = w_empty ? '0 : r_mem[w_top];
  assign stkptr = r_cnt;
  assign full   = w_full;
  assign empty  = w_empty;
  assign stkovf = r_ovf;
  assign stkunf = r_unf;

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = r_wp;
    w_mem_data = push_data;
    w_wp_nxt   = r_wp;
    w_cnt_nxt  = r_cnt;
    w_ovf_set  = 1'b0;
    w_unf_set  = 1'b0;
    if (push) begin
      w_mem_we = 1'b1;
      if (pop && !w_empty) begin
        w_mem_addr = w_top;
      end else begin
        // Plain push, or push+pop on empty which behaves as a push plus underflow.
        w_wp_nxt = r_wp + PTR_W'(1);
        if (w_full) w_ovf_set = 1'b1;
        else        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_unf_set = pop;
      end
    end else if (pop) begin
      if (w_empty) begin
        w_unf_set = 1'b1;
      end else begin
        w_wp_nxt  = w_top;
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end else if (ptr_wr_en) begin
      w_cnt_nxt = w_clamp;
      w_wp_nxt  = w_clamp[PTR_W-1:0];
    end else if (tos_wr_en && !w_empty) begin
      w_mem_we   = 1'b1;
      w_mem_addr = w_top;
      w_mem_data = tos_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) r_mem[w_mem_addr] <= w_mem_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_wp  <= w_wp_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (clr_flags) r_ovf <= 1'b0;
      if (w_unf_set)      r_unf <= 1'b1;
      else if (clr_flags) r_unf <= 1'b0;
    end
  end

`ifdef STACK_FAULT_RST_EN
  logic r_fault_rst_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_fault_rst_req <= 1'b0;
    else if (w_ovf_set || w_unf_set) r_fault_rst_req <= 1'b1;
  end

  assign fault_rst_req = r_fault_rst_req;
`else
  assign fault_rst_req = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack_param.sv
// Randomised and directed bench for call_stack_param against a queue-based stack model.
// Honours STACK_FAULT_RST_EN for the expected fault reset request.
module tb_call_stack_param;
  localparam int AW = 11;
  localparam int D  = 16;
  localparam int CW = 5;
`ifdef STACK_FAULT_RST_EN
  localparam bit FRR_EN = 1'b1;
`else
  localparam bit FRR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          push, pop, tos_wr_en, ptr_wr_en, clr_flags;
  logic [AW-1:0] push_data, tos_wr_data, tos;
  logic [CW-1:0] ptr_wr_data, stkptr;
  logic          full, empty, stkovf, stkunf, fault_rst_req;

  call_stack_param #(.ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data), .tos(tos),
    .tos_wr_en(tos_wr_en), .tos_wr_data(tos_wr_data), .ptr_wr_en(ptr_wr_en),
    .ptr_wr_data(ptr_wr_data), .stkptr(stkptr), .full(full), .empty(empty),
    .clr_flags(clr_flags), .stkovf(stkovf), .stkunf(stkunf), .fault_rst_req(fault_rst_req)
  );

  always #5 clk = ~clk;

  // Model: queue front = oldest entry, back = top of stack.
  logic [AW-1:0] q[$];
  bit m_ovf, m_unf, m_frr;
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("stkptr", 32'(stkptr), q.size());
    chk("tos", 32'(tos), (q.size() > 0) ? 32'(q[q.size()-1]) : 32'd0);
    chk("full", 32'(full), (q.size() == D) ? 32'd1 : 32'd0);
    chk("empty", 32'(empty), (q.size() == 0) ? 32'd1 : 32'd0);
    chk("stkovf", 32'(stkovf), 32'(m_ovf));
    chk("stkunf", 32'(stkunf), 32'(m_unf));
    chk("fault_rst_req", 32'(fault_rst_req), 32'(m_frr & FRR_EN));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_frr = 0;
  endtask

  // ptr writes are only used while memory slot i holds 0x100+i.
  task automatic step(input bit pu, input bit po, input logic [AW-1:0] d,
                      input bit tw, input logic [AW-1:0] td,
                      input bit pw, input int unsigned pd, input bit clr);
    bit os, us;
    int unsigned n;
    push = pu; pop = po; push_data = d; tos_wr_en = tw; tos_wr_data = td;
    ptr_wr_en = pw; ptr_wr_data = CW'(pd); clr_flags = clr;
    @(posedge clk);
    os = 0; us = 0;
    if (pu && po) begin
      if (q.size() == 0) begin q.push_back(d); us = 1; end
      else q[q.size()-1] = d;
    end else if (pu) begin
      if (q.size() == D) begin void'(q.pop_front()); os = 1; end
      q.push_back(d);
    end else if (po) begin
      if (q.size() == 0) us = 1;
      else void'(q.pop_back());
    end else if (pw) begin
      n = (pd > D) ? D : pd;
      q.delete();
      for (int unsigned i = 0; i < n; i++) q.push_back(AW'(32'h100 + i));
    end else if (tw && q.size() > 0) begin
      q[q.size()-1] = td;
    end
    m_ovf = os ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = us ? 1'b1 : (clr ? 1'b0 : m_unf);
    if (os || us) m_frr = 1;
    #1;
    push = 0; pop = 0; tos_wr_en = 0; ptr_wr_en = 0; clr_flags = 0;
    check_all();
  endtask

  task automatic do_push(input logic [AW-1:0] d);
    step(1, 0, d, 0, '0, 0, 0, 0);
  endtask

  task automatic do_pop();
    step(0, 1, '0, 0, '0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse between edges; checked before any clock edge occurs.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    int unsigned r;
    rst = 1'b1; push = 0; pop = 0; push_data = '0; tos_wr_en = 0; tos_wr_data = '0;
    ptr_wr_en = 0; ptr_wr_data = '0; clr_flags = 0;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1'b0;

    // Fill, then drain in LIFO order.
    for (int i = 1; i <= 16; i++) do_push(AW'(i));
    chk("fill_stkptr", 32'(stkptr), 16);
    chk("fill_tos", 32'(tos), 32'h010);
    for (int i = 16; i >= 1; i--) begin
      chk("drain_tos", 32'(tos), 32'(i));
      do_pop();
    end
    chk("drain_empty", 32'(empty), 1);

    // Overflow overwrites the oldest entry.
    for (int i = 1; i <= 16; i++) do_push(AW'(i));
    do_push(11'h7FF);
    chk("ovf_flag", 32'(stkovf), 1);
    chk("ovf_tos", 32'(tos), 32'h7FF);
    chk("ovf_frr", 32'(fault_rst_req), 32'(FRR_EN));
    step(0, 0, '0, 0, '0, 0, 0, 1);
    chk("frr_after_clr", 32'(fault_rst_req), 32'(FRR_EN));
    chk("ovf_cleared", 32'(stkovf), 0);
    chk("ovf_pop0", 32'(tos), 32'h7FF);
    do_pop();
    for (int i = 16; i >= 2; i--) begin
      chk("ovf_pop", 32'(tos), 32'(i));
      do_pop();
    end
    chk("ovf_drained", 32'(stkptr), 0);

    // Underflow; set beats clear in the same cycle.
    do_pop();
    chk("unf_flag", 32'(stkunf), 1);
    step(0, 1, '0, 0, '0, 0, 0, 1);
    chk("unf_set_wins", 32'(stkunf), 1);
    step(0, 0, '0, 0, '0, 0, 0, 1);
    chk("unf_cleared", 32'(stkunf), 0);

    // Replace top with simultaneous push and pop.
    do_push(11'h123);
    do_push(11'h234);
    step(1, 1, 11'h345, 0, '0, 0, 0, 0);
    chk("pp_stkptr", 32'(stkptr), 2);
    chk("pp_tos", 32'(tos), 32'h345);
    do_pop();
    chk("pp_pop", 32'(tos), 32'h123);

    // TOS write on one entry, then on empty.
    step(0, 0, '0, 1, 11'h0AA, 0, 0, 0);
    chk("toswr", 32'(tos), 32'h0AA);
    do_pop();
    step(0, 0, '0, 1, 11'h155, 0, 0, 0);
    chk("toswr_empty", 32'(tos), 0);
    step(1, 1, 11'h066, 0, '0, 0, 0, 0);
    chk("pp_empty_unf", 32'(stkunf), 1);

    // Pointer writes with memory slot i holding 0x100+i.
    async_reset();
    for (int i = 0; i < 16; i++) do_push(AW'(32'h100 + i));
    step(0, 0, '0, 0, '0, 1, 3, 0);
    chk("ptrwr3_tos", 32'(tos), 32'h102);
    step(0, 0, '0, 1, 11'h0BB, 1, 7, 0);
    chk("ptrwr_beats_toswr", 32'(stkptr), 7);
    step(0, 0, '0, 0, '0, 1, 20, 0);
    chk("ptrwr20_stkptr", 32'(stkptr), 16);
    step(1, 0, 11'h1FF, 0, '0, 1, 2, 0);
    chk("push_beats_ptrwr", 32'(tos), 32'h1FF);

    async_reset();
    chk("rst_frr", 32'(fault_rst_req), 0);

    // Random traffic (no pointer writes: memory layout is no longer known).
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 38)      step(1, 0, AW'($urandom), 0, '0, 0, 0, ($urandom_range(0, 15) == 0));
      else if (r < 70) step(0, 1, '0, 0, '0, 0, 0, ($urandom_range(0, 15) == 0));
      else if (r < 80) step(1, 1, AW'($urandom), 0, '0, 0, 0, ($urandom_range(0, 15) == 0));
      else if (r < 90) step(0, 0, '0, 1, AW'($urandom), 0, 0, 0);
      else             step(0, 0, '0, 0, '0, 0, 0, ($urandom_range(0, 3) == 0));
      if (k == 300) async_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
